// File: rtl/bpsk_demap_serializer.sv
// BPSK hard-decision and erasure demapper for 16 equalized subcarriers, with a
// small symbol FIFO that streams decisions out OUT_W bits per valid/ready beat.
module bpsk_demap_serializer #(
    parameter int unsigned     WIDTH  = 16,
    parameter int unsigned     NSC    = 16,
    parameter int unsigned     OUT_W  = 8,
    parameter int unsigned     DEPTH  = 2,
    parameter logic [WIDTH-1:0] THRESH = 16'h0040
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din0_real,
    input  logic [WIDTH-1:0] din1_real,
    input  logic [WIDTH-1:0] din2_real,
    input  logic [WIDTH-1:0] din3_real,
    input  logic [WIDTH-1:0] din4_real,
    input  logic [WIDTH-1:0] din5_real,
    input  logic [WIDTH-1:0] din6_real,
    input  logic [WIDTH-1:0] din7_real,
    input  logic [WIDTH-1:0] din8_real,
    input  logic [WIDTH-1:0] din9_real,
    input  logic [WIDTH-1:0] din10_real,
    input  logic [WIDTH-1:0] din11_real,
    input  logic [WIDTH-1:0] din12_real,
    input  logic [WIDTH-1:0] din13_real,
    input  logic [WIDTH-1:0] din14_real,
    input  logic [WIDTH-1:0] din15_real,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [OUT_W-1:0] dout_bits,
    output logic [OUT_W-1:0] dout_eras,
    output logic             dout_last,
    output logic             overflow,
    output logic [15:0]      sym_cnt
);

    localparam int unsigned NBEATS = NSC / OUT_W;
    localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam int unsigned EW     = 2 * NSC;

    logic [WIDTH-1:0] w_din [NSC];
    logic [NSC-1:0]   w_bits;
    logic [NSC-1:0]   w_eras;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic             w_xfer;
    logic             w_last;
    logic             w_pop;
    logic [CW-1:0]    w_count_d;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [BW-1:0]    r_beat;
    logic             r_overflow;
    logic [15:0]      r_sym_cnt;

    assign w_din[0]  = din0_real;
    assign w_din[1]  = din1_real;
    assign w_din[2]  = din2_real;
    assign w_din[3]  = din3_real;
    assign w_din[4]  = din4_real;
    assign w_din[5]  = din5_real;
    assign w_din[6]  = din6_real;
    assign w_din[7]  = din7_real;
    assign w_din[8]  = din8_real;
    assign w_din[9]  = din9_real;
    assign w_din[10] = din10_real;
    assign w_din[11] = din11_real;
    assign w_din[12] = din12_real;
    assign w_din[13] = din13_real;
    assign w_din[14] = din14_real;
    assign w_din[15] = din15_real;

    // Magnitude with the most negative code clamped to the largest positive value.
    function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] n;
        n = '0 - x;
        if (!x[WIDTH-1]) begin
            return x;
        end else if (n[WIDTH-1]) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            return n;
        end
    endfunction

    always_comb begin
        w_bits = '0;
        w_eras = '0;
        for (int k = 0; k < NSC; k++) begin
            w_bits[k] = w_din[k][WIDTH-1];
            w_eras[k] = (sat_abs(w_din[k]) < THRESH);
        end
    end

    assign w_entry = {w_eras, w_bits};
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = in_valid & ~w_full;
    assign w_drop  = in_valid & w_full;
    assign w_xfer  = dout_valid & dout_ready;
    assign w_last  = (r_beat == BW'(NBEATS - 1));
    assign w_pop   = w_xfer & w_last;

    always_comb begin
        w_count_d = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CW'(1);
            2'b01:   w_count_d = r_count - CW'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
            r_sym_cnt  <= '0;
        end else begin
            // A full FIFO rejects the symbol even if the head pops on this edge.
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
                r_sym_cnt       <= r_sym_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_xfer) begin
                if (w_last) begin
                    r_beat   <= '0;
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end else begin
                    r_beat <= r_beat + BW'(1);
                end
            end
            r_count <= w_count_d;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign dout_valid = (r_count != '0);
    assign dout_bits  = w_head[r_beat * OUT_W +: OUT_W];
    assign dout_eras  = w_head[NSC + r_beat * OUT_W +: OUT_W];
    assign dout_last  = w_last;
    assign overflow   = r_overflow;
    assign sym_cnt    = r_sym_cnt;

endmodule

// File: tb/tb_bpsk_demap_serializer.sv
// Bench for bpsk_demap_serializer: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_bpsk_demap_serializer;

    localparam int DEPTH  = 2;
    localparam int NBEATS = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] tb_din [16];
    logic        dout_valid;
    logic        dout_ready;
    logic [7:0]  dout_bits;
    logic [7:0]  dout_eras;
    logic        dout_last;
    logic        overflow;
    logic [15:0] sym_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of whole symbols {eras[15:0], bits[15:0]}.
    logic [31:0] m_q [$];
    int          m_beat;
    logic        m_ovf;
    logic [15:0] m_sym;

    typedef struct {
        logic [15:0][15:0] din;
        logic [7:0]        b0;
        logic [7:0]        e0;
        logic [7:0]        b1;
        logic [7:0]        e1;
    } vec_t;

    vec_t tbl [4];

    bpsk_demap_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .din0_real  (tb_din[0]),
        .din1_real  (tb_din[1]),
        .din2_real  (tb_din[2]),
        .din3_real  (tb_din[3]),
        .din4_real  (tb_din[4]),
        .din5_real  (tb_din[5]),
        .din6_real  (tb_din[6]),
        .din7_real  (tb_din[7]),
        .din8_real  (tb_din[8]),
        .din9_real  (tb_din[9]),
        .din10_real (tb_din[10]),
        .din11_real (tb_din[11]),
        .din12_real (tb_din[12]),
        .din13_real (tb_din[13]),
        .din14_real (tb_din[14]),
        .din15_real (tb_din[15]),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_bits  (dout_bits),
        .dout_eras  (dout_eras),
        .dout_last  (dout_last),
        .overflow   (overflow),
        .sym_cnt    (sym_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_sym();
        logic [15:0] b;
        logic [15:0] e;
        for (int k = 0; k < 16; k++) begin
            int v;
            int a;
            v = $signed(tb_din[k]);
            a = (v < 0) ? -v : v;
            if (a > 32767) a = 32767;
            b[k] = (v < 0);
            e[k] = (a < 64);
        end
        return {e, b};
    endfunction

    task automatic check_outputs();
        logic [31:0] h;
        chk("valid", 32'(dout_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            h = m_q[0];
            chk("bits", 32'(dout_bits), 32'(h[m_beat*8 +: 8]));
            chk("eras", 32'(dout_eras), 32'(h[16 + m_beat*8 +: 8]));
            chk("last", 32'(dout_last), 32'(m_beat == NBEATS - 1));
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("sym_cnt", 32'(sym_cnt), 32'(m_sym));
    endtask

    // Entered and left at a falling edge; the model advances for the rising edge between.
    task automatic step(input logic iv, input logic rdy);
        logic has_room;
        in_valid   = iv;
        dout_ready = rdy;
        check_outputs();
        has_room = (m_q.size() < DEPTH);
        if (m_q.size() != 0 && rdy) begin
            if (m_beat == NBEATS - 1) begin
                void'(m_q.pop_front());
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (iv) begin
            if (has_room) begin
                m_q.push_back(ref_sym());
                m_sym++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic model_clear();
        m_q.delete();
        m_beat = 0;
        m_ovf  = 1'b0;
        m_sym  = '0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        dout_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int k = 0; k < 16; k++) tb_din[k] = v;
    endtask

    task automatic load_vec(input int i);
        for (int k = 0; k < 16; k++) tb_din[k] = tbl[i].din[k];
    endtask

    task automatic rand_din();
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
                0: tb_din[k] = 16'($urandom);
                1: tb_din[k] = 16'(int'($urandom_range(0, 200)) - 100);
                2: tb_din[k] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
                default: tb_din[k] = 16'($urandom_range(0, 65535));
            endcase
        end
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        in_valid   = 1'b0;
        dout_ready = 1'b0;
        set_all(16'h0000);
        model_clear();

        // Vector table: {din[16], beat0 bits/eras, beat1 bits/eras}.
        for (int k = 0; k < 16; k++) begin
            tbl[0].din[k] = (k < 8) ? 16'h0100 : 16'hFF00;
            tbl[1].din[k] = 16'h0200;
            tbl[2].din[k] = 16'h0000;
            if (k < 8) tbl[3].din[k] = (k % 2 == 0) ? 16'h0040 : 16'h003F;
            else       tbl[3].din[k] = (k % 2 == 0) ? 16'hFFC0 : 16'hFFC1;
        end
        tbl[1].din[3] = 16'h0020;
        tbl[1].din[4] = 16'hFFD0;
        tbl[1].din[5] = 16'h8000;
        tbl[0].b0 = 8'h00; tbl[0].e0 = 8'h00; tbl[0].b1 = 8'hFF; tbl[0].e1 = 8'h00;
        tbl[1].b0 = 8'h30; tbl[1].e0 = 8'h18; tbl[1].b1 = 8'h00; tbl[1].e1 = 8'h00;
        tbl[2].b0 = 8'h00; tbl[2].e0 = 8'hFF; tbl[2].b1 = 8'h00; tbl[2].e1 = 8'hFF;
        tbl[3].b0 = 8'h00; tbl[3].e0 = 8'hAA; tbl[3].b1 = 8'hFF; tbl[3].e1 = 8'hAA;

        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            chk("rst_valid", 32'(dout_valid), 0);
            chk("rst_bits", 32'(dout_bits), 0);
            chk("rst_eras", 32'(dout_eras), 0);
            chk("rst_last", 32'(dout_last), 0);
            chk("rst_overflow", 32'(overflow), 0);
            chk("rst_sym_cnt", 32'(sym_cnt), 0);
            load_vec(i);
            step(1'b1, 1'b1);
            chk("vec_valid0", 32'(dout_valid), 1);
            chk("vec_bits0", 32'(dout_bits), 32'(tbl[i].b0));
            chk("vec_eras0", 32'(dout_eras), 32'(tbl[i].e0));
            chk("vec_last0", 32'(dout_last), 0);
            step(1'b0, 1'b1);
            chk("vec_bits1", 32'(dout_bits), 32'(tbl[i].b1));
            chk("vec_eras1", 32'(dout_eras), 32'(tbl[i].e1));
            chk("vec_last1", 32'(dout_last), 1);
            step(1'b0, 1'b1);
            chk("vec_drained", 32'(dout_valid), 0);
            chk("vec_sym_cnt", 32'(sym_cnt), 1);
        end

        // Three back-to-back symbols into a stalled two-entry FIFO.
        do_reset();
        load_vec(0); step(1'b1, 1'b0);
        load_vec(1); step(1'b1, 1'b0);
        load_vec(3); step(1'b1, 1'b0);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_sym_cnt", 32'(sym_cnt), 2);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (dout_valid) n++;
            step(1'b0, 1'b1);
        end
        chk("t3_beats", 32'(n), 4);
        chk("t3_overflow_sticky", 32'(overflow), 1);

        // Capture coinciding with the final-beat pop: full drops, count==1 accepts.
        do_reset();
        load_vec(0); step(1'b1, 1'b0);
        load_vec(1); step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        load_vec(2); step(1'b1, 1'b1);
        chk("t5_full_drop_ovf", 32'(overflow), 1);
        chk("t5_full_drop_cnt", 32'(sym_cnt), 2);
        step(1'b0, 1'b1);
        load_vec(3); step(1'b1, 1'b1);
        chk("t5_accept_cnt", 32'(sym_cnt), 3);
        chk("t5_accept_valid", 32'(dout_valid), 1);
        chk("t5_accept_bits0", 32'(dout_bits), 32'(tbl[3].b0));
        chk("t5_accept_last0", 32'(dout_last), 0);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (dout_valid) n++;
            step(1'b0, 1'b1);
        end
        chk("t5_tail_beats", 32'(n), 2);

        // Asynchronous reset in the middle of a symbol.
        do_reset();
        load_vec(1); step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("t6_mid_last", 32'(dout_last), 1);
        #2 rst = 1'b1;
        #1 chk("t6_async_valid", 32'(dout_valid), 0);
        chk("t6_async_sym_cnt", 32'(sym_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        load_vec(0); step(1'b1, 1'b1);
        chk("t6_restart_last", 32'(dout_last), 0);
        chk("t6_restart_bits", 32'(dout_bits), 32'(tbl[0].b0));
        step(1'b0, 1'b1);
        chk("t6_restart_bits1", 32'(dout_bits), 32'(tbl[0].b1));
        step(1'b0, 1'b1);

        // Randomized traffic with random backpressure.
        do_reset();
        for (int s = 0; s < 100; s++) begin
            int guard;
            int gap;
            guard = 0;
            while (m_q.size() >= DEPTH && guard < 50) begin
                step(1'b0, 1'($urandom_range(0, 1)));
                guard++;
            end
            rand_din();
            step(1'b1, 1'($urandom_range(0, 1)));
            gap = 3 + $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)));
        end
        for (int c = 0; c < 20; c++) step(1'b0, 1'b1);
        chk("rand_no_drop", 32'(overflow), 0);
        chk("rand_sym_cnt", 32'(sym_cnt), 100);
        chk("rand_drained", 32'(dout_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
